cam_frame_writer: RTL and testbench
===================================

Name: cam_frame_writer

Overview:
- Write side of the camera frame buffer; the display scaler reads this buffer.
- Takes the camera byte stream (pixel clock, hsync, vsync, 8-bit data) already synchronised into clk_in.
- Packs byte pairs into RGB565 pixels.
- Emits one-cycle BRAM write strobes with linear address row*WIDTH+col into a WIDTH x HEIGHT buffer (240 x 320).
- Crops anything outside the buffer and flags each completed frame.

Parameters:
WIDTH, 240, pixels per buffer row; columns >= WIDTH dropped
HEIGHT, 320, buffer rows; rows >= HEIGHT dropped
ADDR_W, 17, address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT (76800)

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst_in  input  1  asynchronous, active-high reset
cam_pclk_in  input  1  camera pixel clock, already synchronised to clk_in
cam_hsync_in  input  1  high during active line bytes
cam_vsync_in  input  1  high during inter-frame blanking
cam_data_in  input  8  camera byte, valid at pclk rising edge
pixel_addr_out  output  ADDR_W  buffer write address
pixel_data_out  output  16  RGB565 pixel, first byte in [15:8]
pixel_valid_out  output  1  one-cycle write strobe
frame_done_out  output  1  one-cycle pulse at end of frame
row_out  output  10  current row counter, debug

Behaviour:
- Reset: all outputs 0; state SYNC; col, row, line_base, byte_phase = 0; pclk_prev = 0.
- Sample point: cycle where cam_pclk_in=1 and pclk_prev=0. pclk_prev <= cam_pclk_in every cycle. Only sample points act on hsync/vsync/data; all other cycles are idle.
- Latency: outputs registered; they appear on the clk_in edge ending the sample-point cycle, i.e. visible 1 cycle after the sample point.
- pixel_valid_out and frame_done_out are high for exactly 1 cycle per event. pixel_addr_out and pixel_data_out hold their last values otherwise.
- State SYNC:
  - Ignore all input until a sample point sees vsync=1, then go to VBLANK.
  - This guarantees a clean frame start after reset.
- State VBLANK:
  - Sample point with vsync=0 -> FRAME, with col=row=line_base=byte_phase=0.
- State FRAME, at each sample point, in priority order:
  1. vsync=1: pulse frame_done_out; clear col, row, line_base, byte_phase; go to VBLANK. Any pending half-pixel byte is discarded.
  2. hsync=1, byte_phase=0: hi_byte <= data; byte_phase <= 1.
  3. hsync=1, byte_phase=1:
     - pixel = {hi_byte, data}; byte_phase <= 0.
     - If col<WIDTH and row<HEIGHT: pixel_valid_out=1, pixel_addr_out = line_base+col, pixel_data_out = pixel.
     - col <= col+1, saturating at 1023.
  4. hsync=0 with hsync_prev=1 (line end): row <= row+1 saturating at 1023; line_base <= line_base+WIDTH only while row<HEIGHT; col <= 0; byte_phase <= 0. A dangling odd byte is dropped.
  5. hsync=0 otherwise: no action.
- hsync_prev updates only at sample points.
- The address is built from the incremental line_base only; no multiplier.
- Maximum address is WIDTH*HEIGHT-1 = 76799; it never exceeds this.
- vsync high together with hsync high: vsync wins, no pixel written.
- rst_in asserted mid-frame: immediate return to reset values. Writing resumes only after a full vsync high -> low sequence.
- pclk held static: no activity, no outputs change.
- row_out = row.

Test Plan:
- Reset then one line, no prior vsync: 4 bytes on hsync -> no pixel_valid_out (stays in SYNC). Then vsync 1->0 and bytes 0xA8,0x31,0xFF,0x00 -> strobes addr 0 data 0xA831, then addr 1 data 0xFF00, each 1 cycle after its second-byte sample point.
- Line wrap: 3 lines of 2 pixels each -> addresses 0,1, 240,241, 480,481. row_out ends at 3.
- Horizontal crop: line of 242 pixels -> exactly 240 strobes, last addr 239. Next line starts at 240.
- Vertical crop: 322 lines of 1 pixel -> 320 strobes, last addr 319*240 = 76560. No write for rows 320 and 321.
- Odd byte and mid-line vsync:
  - Line of 3 bytes -> 1 strobe; next line's first pixel at addr 240 with correct byte order.
  - vsync rising mid-line -> single frame_done_out pulse, no strobe; next frame restarts at addr 0.
- Async reset mid-frame: assert rst_in for 1 ns between clock edges -> outputs 0 immediately. Subsequent bytes without vsync produce no writes.

Source files
------------

// File: rtl/cam_frame_writer.sv
// cam_frame_writer
// Write side of the camera frame buffer. The camera byte stream arrives
// already synchronised into clk_in. Each rising edge of the camera pixel
// clock is one sample point. Byte pairs taken while hsync is high are packed
// into RGB565 pixels, first byte in the upper half. Each pixel becomes a
// one-cycle BRAM write strobe at the linear address row*WIDTH+col. Columns
// and rows outside the WIDTH x HEIGHT buffer are cropped. Every completed
// frame produces a one-cycle frame_done_out pulse.
//
// Ports:
//   clk_in          system clock, all logic on its rising edge
//   rst_in          asynchronous active-high reset
//   cam_pclk_in     camera pixel clock (synchronised)
//   cam_hsync_in    high during active line bytes
//   cam_vsync_in    high during inter-frame blanking
//   cam_data_in     camera byte
//   pixel_addr_out  buffer write address
//   pixel_data_out  RGB565 pixel
//   pixel_valid_out one-cycle write strobe
//   frame_done_out  one-cycle end-of-frame pulse
//   row_out         current row counter (debug)
module cam_frame_writer #(
    parameter int WIDTH  = 240,
    parameter int HEIGHT = 320,
    parameter int ADDR_W = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              cam_pclk_in,
    input  logic              cam_hsync_in,
    input  logic              cam_vsync_in,
    input  logic [7:0]        cam_data_in,
    output logic [ADDR_W-1:0] pixel_addr_out,
    output logic [15:0]       pixel_data_out,
    output logic              pixel_valid_out,
    output logic              frame_done_out,
    output logic [9:0]        row_out
);

    typedef enum logic [1:0] {SYNC, VBLANK, FRAME} state_t;

    localparam logic [9:0]        COL_MAX = 10'd1023;
    localparam logic [9:0]        WIDTH_C = 10'(WIDTH);
    localparam logic [9:0]        HEIGHT_C = 10'(HEIGHT);
    localparam logic [ADDR_W-1:0] WIDTH_A = ADDR_W'(WIDTH);

    state_t            r_state, w_stateNext;
    logic              r_pclkPrev;
    logic              r_hsyncPrev, w_hsyncPrevNext;
    logic [9:0]        r_col, w_colNext;
    logic [9:0]        r_row, w_rowNext;
    logic [ADDR_W-1:0] r_lineBase, w_lineBaseNext;
    logic              r_bytePhase, w_bytePhaseNext;
    logic [7:0]        r_hiByte, w_hiByteNext;
    logic [ADDR_W-1:0] r_addr, w_addrNext;
    logic [15:0]       r_data, w_dataNext;
    logic              r_valid, w_validNext;
    logic              r_frameDone, w_frameDoneNext;
    logic              w_sample;

    // Only the rising edge of the pixel clock carries a byte; every other
    // cycle leaves all state untouched.
    assign w_sample = cam_pclk_in & ~r_pclkPrev;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state     <= SYNC;
            r_pclkPrev  <= 1'b0;
            r_hsyncPrev <= 1'b0;
            r_col       <= '0;
            r_row       <= '0;
            r_lineBase  <= '0;
            r_bytePhase <= 1'b0;
            r_hiByte    <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_pclkPrev  <= cam_pclk_in;
            r_hsyncPrev <= w_hsyncPrevNext;
            r_col       <= w_colNext;
            r_row       <= w_rowNext;
            r_lineBase  <= w_lineBaseNext;
            r_bytePhase <= w_bytePhaseNext;
            r_hiByte    <= w_hiByteNext;
            r_addr      <= w_addrNext;
            r_data      <= w_dataNext;
            r_valid     <= w_validNext;
            r_frameDone <= w_frameDoneNext;
        end
    end

    // The frame sequencing and the pixel datapath are both resolved here.
    // The SYNC state waits for a vsync pulse, so a frame that was already
    // under way when reset was released is never written. The address is
    // the running line base plus the column. The line base only advances
    // while the row is inside the buffer, so the address cannot run past
    // the last buffer location.
    always_comb begin
        w_stateNext      = r_state;
        w_hsyncPrevNext  = r_hsyncPrev;
        w_colNext        = r_col;
        w_rowNext        = r_row;
        w_lineBaseNext   = r_lineBase;
        w_bytePhaseNext  = r_bytePhase;
        w_hiByteNext     = r_hiByte;
        w_addrNext       = r_addr;
        w_dataNext       = r_data;
        w_validNext      = 1'b0;
        w_frameDoneNext  = 1'b0;

        if (w_sample) begin
            w_hsyncPrevNext = cam_hsync_in;
            case (r_state)
                SYNC: begin
                    if (cam_vsync_in) begin
                        w_stateNext = VBLANK;
                    end
                end
                VBLANK: begin
                    if (!cam_vsync_in) begin
                        w_stateNext     = FRAME;
                        w_colNext       = '0;
                        w_rowNext       = '0;
                        w_lineBaseNext  = '0;
                        w_bytePhaseNext = 1'b0;
                    end
                end
                FRAME: begin
                    if (cam_vsync_in) begin
                        // vsync beats a simultaneous hsync byte and drops any half pixel
                        w_frameDoneNext = 1'b1;
                        w_stateNext     = VBLANK;
                        w_colNext       = '0;
                        w_rowNext       = '0;
                        w_lineBaseNext  = '0;
                        w_bytePhaseNext = 1'b0;
                    end else if (cam_hsync_in) begin
                        if (!r_bytePhase) begin
                            w_hiByteNext    = cam_data_in;
                            w_bytePhaseNext = 1'b1;
                        end else begin
                            w_bytePhaseNext = 1'b0;
                            if ((r_col < WIDTH_C) && (r_row < HEIGHT_C)) begin
                                w_validNext = 1'b1;
                                w_addrNext  = r_lineBase + ADDR_W'(r_col);
                                w_dataNext  = {r_hiByte, cam_data_in};
                            end
                            if (r_col != COL_MAX) begin
                                w_colNext = r_col + 10'd1;
                            end
                        end
                    end else if (r_hsyncPrev) begin
                        // falling hsync closes the line; an odd trailing byte is lost
                        if (r_row != COL_MAX) begin
                            w_rowNext = r_row + 10'd1;
                        end
                        if (r_row < HEIGHT_C) begin
                            w_lineBaseNext = r_lineBase + WIDTH_A;
                        end
                        w_colNext       = '0;
                        w_bytePhaseNext = 1'b0;
                    end
                end
                default: begin
                    w_stateNext = SYNC;
                end
            endcase
        end
    end

    assign pixel_addr_out  = r_addr;
    assign pixel_data_out  = r_data;
    assign pixel_valid_out = r_valid;
    assign frame_done_out  = r_frameDone;
    assign row_out         = r_row;

endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer
// Directed bench for cam_frame_writer. Each camera byte lasts three system
// clocks: one clock with pclk low, then two clocks with pclk high. A monitor
// counts write strobes and frame_done pulses, and it remembers the last
// written address and data.
module tb_cam_frame_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pclk = 1'b0;
    logic        hsync = 1'b0;
    logic        vsync = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [16:0] pixelAddr;
    logic [15:0] pixelData;
    logic        pixelValid;
    logic        frameDone;
    logic [9:0]  rowOut;

    int          checks = 0;
    int          errors = 0;
    int          strobeCount = 0;
    int          frameDoneCount = 0;
    logic [16:0] lastAddr = '0;
    logic [15:0] lastData = '0;
    logic        validAfter = 1'b0;
    int          s0;
    int          f0;

    cam_frame_writer #(.WIDTH(240), .HEIGHT(320), .ADDR_W(17)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .cam_pclk_in     (pclk),
        .cam_hsync_in    (hsync),
        .cam_vsync_in    (vsync),
        .cam_data_in     (data),
        .pixel_addr_out  (pixelAddr),
        .pixel_data_out  (pixelData),
        .pixel_valid_out (pixelValid),
        .frame_done_out  (frameDone),
        .row_out         (rowOut)
    );

    always #5 clk = ~clk;

    // Tally every strobe cycle, so a strobe that lasts two cycles counts twice.
    always @(negedge clk) begin
        if (pixelValid) begin
            strobeCount = strobeCount + 1;
            lastAddr    = pixelAddr;
            lastData    = pixelData;
        end
        if (frameDone) begin
            frameDoneCount = frameDoneCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One camera byte. validAfter holds the strobe as it looks one clock
    // after the sample point.
    task automatic applyStimulus(input logic hs, input logic vs, input logic [7:0] d);
        pclk  = 1'b0;
        hsync = hs;
        vsync = vs;
        data  = d;
        @(negedge clk); #1;
        pclk = 1'b1;
        @(negedge clk); #1;
        validAfter = pixelValid;
        @(negedge clk); #1;
    endtask

    task automatic sendPixel(input logic [7:0] hi, input logic [7:0] lo);
        applyStimulus(1'b1, 1'b0, hi);
        applyStimulus(1'b1, 1'b0, lo);
    endtask

    task automatic lineEnd();
        applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frameEnd();
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk); #1;
        checkOutput("reset_addr", 32'(pixelAddr), 32'd0);
        checkOutput("reset_data", 32'(pixelData), 32'd0);
        checkOutput("reset_valid", 32'(pixelValid), 32'd0);
        checkOutput("reset_done", 32'(frameDone), 32'd0);
        checkOutput("reset_row", 32'(rowOut), 32'd0);

        // Bytes before any vsync are ignored
        sendPixel(8'h11, 8'h22);
        sendPixel(8'h33, 8'h44);
        checkOutput("sync_no_write", 32'(strobeCount), 32'd0);

        // First frame: two pixels on line 0
        frameEnd();
        applyStimulus(1'b1, 1'b0, 8'hA8);
        applyStimulus(1'b1, 1'b0, 8'h31);
        checkOutput("px0_latency", 32'(validAfter), 32'd1);
        checkOutput("px0_addr", 32'(lastAddr), 32'd0);
        checkOutput("px0_data", 32'(lastData), 32'hA831);
        sendPixel(8'hFF, 8'h00);
        checkOutput("px1_addr", 32'(lastAddr), 32'd1);
        checkOutput("px1_data", 32'(lastData), 32'hFF00);
        checkOutput("px_count", 32'(strobeCount), 32'd2);

        // Line wrap
        lineEnd();
        sendPixel(8'h01, 8'h02);
        checkOutput("wrap_240", 32'(lastAddr), 32'd240);
        sendPixel(8'h03, 8'h04);
        checkOutput("wrap_241", 32'(lastAddr), 32'd241);
        lineEnd();
        sendPixel(8'h05, 8'h06);
        checkOutput("wrap_480", 32'(lastAddr), 32'd480);
        sendPixel(8'h07, 8'h08);
        checkOutput("wrap_481", 32'(lastAddr), 32'd481);
        checkOutput("wrap_data", 32'(lastData), 32'h0708);
        lineEnd();
        checkOutput("wrap_row", 32'(rowOut), 32'd3);
        checkOutput("wrap_count", 32'(strobeCount), 32'd6);

        // Frame end pulse
        f0 = frameDoneCount;
        frameEnd();
        checkOutput("frame_done_pulse", 32'(frameDoneCount - f0), 32'd1);
        checkOutput("frame_row_clear", 32'(rowOut), 32'd0);

        // Horizontal crop
        s0 = strobeCount;
        for (int i = 0; i < 242; i++) begin
            sendPixel(i[7:0], 8'h5A);
        end
        checkOutput("hcrop_count", 32'(strobeCount - s0), 32'd240);
        checkOutput("hcrop_last", 32'(lastAddr), 32'd239);
        lineEnd();
        sendPixel(8'hBE, 8'hEF);
        checkOutput("hcrop_next_line", 32'(lastAddr), 32'd240);
        frameEnd();

        // Vertical crop
        s0 = strobeCount;
        for (int r = 0; r < 322; r++) begin
            sendPixel(r[7:0], 8'hC0);
            lineEnd();
        end
        checkOutput("vcrop_count", 32'(strobeCount - s0), 32'd320);
        checkOutput("vcrop_last", 32'(lastAddr), 32'd76560);
        checkOutput("vcrop_row", 32'(rowOut), 32'd322);
        frameEnd();

        // Odd byte on a line is dropped
        s0 = strobeCount;
        applyStimulus(1'b1, 1'b0, 8'h12);
        applyStimulus(1'b1, 1'b0, 8'h34);
        applyStimulus(1'b1, 1'b0, 8'h56);
        checkOutput("odd_count", 32'(strobeCount - s0), 32'd1);
        lineEnd();
        sendPixel(8'h9A, 8'hBC);
        checkOutput("odd_next_addr", 32'(lastAddr), 32'd240);
        checkOutput("odd_next_data", 32'(lastData), 32'h9ABC);

        // vsync mid-line with hsync high: frame ends, no write
        applyStimulus(1'b1, 1'b0, 8'h77);
        s0 = strobeCount;
        f0 = frameDoneCount;
        applyStimulus(1'b1, 1'b1, 8'h88);
        checkOutput("midv_no_write", 32'(strobeCount - s0), 32'd0);
        checkOutput("midv_done", 32'(frameDoneCount - f0), 32'd1);
        applyStimulus(1'b0, 1'b0, 8'h00);
        sendPixel(8'h11, 8'h22);
        checkOutput("midv_restart_addr", 32'(lastAddr), 32'd0);
        checkOutput("midv_restart_data", 32'(lastData), 32'h1122);

        // Async reset mid-frame
        lineEnd();
        sendPixel(8'h5A, 8'hA5);
        checkOutput("pre_rst_addr", 32'(lastAddr), 32'd240);
        applyStimulus(1'b1, 1'b0, 8'h33);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("arst_addr", 32'(pixelAddr), 32'd0);
        checkOutput("arst_data", 32'(pixelData), 32'd0);
        checkOutput("arst_row", 32'(rowOut), 32'd0);
        rst = 1'b0;
        s0 = strobeCount;
        sendPixel(8'h01, 8'h02);
        sendPixel(8'h03, 8'h04);
        checkOutput("arst_no_write", 32'(strobeCount - s0), 32'd0);
        frameEnd();
        sendPixel(8'hC3, 8'h3C);
        checkOutput("arst_resume_addr", 32'(lastAddr), 32'd0);
        checkOutput("arst_resume_data", 32'(lastData), 32'hC33C);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
